// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator for the DataMemory port.
// Aligned accesses are issued in a single ACCESS cycle. Misaligned H/W accesses
// are split into byte accesses (SPLIT) and reassembled. Every response is held in
// RESP until the consumer takes it.
module lsu_mem_master #(
    parameter int unsigned MEM_BYTES        = 1024,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWr,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    input  logic [2:0]  ReqFunct3,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] RspRData,
    output logic        RspErr,
    output logic [31:0] Address,
    output logic [31:0] DataWr,
    output logic        DMWr,
    output logic [2:0]  DMCtrl,
    input  logic [31:0] DataRd
);

    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

    state_t      state, state_nxt;

    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic        err_q;
    logic [1:0]  cnt_q;
    logic [31:0] asm_q;
    logic [31:0] rdata_q;
    logic        rsp_err_q;

    logic [2:0]  size;
    logic [32:0] end_addr;
    logic        illegal;
    logic        out_of_range;
    logic        misaligned;
    logic        req_err;
    logic        req_split;
    logic [1:0]  last_k;
    logic [31:0] asm_nxt;
    logic [31:0] split_rdata;

    // Classify the incoming request: access size, legality, range and alignment.
    always_comb begin
        case (ReqFunct3[1:0])
            2'b01:   size = 3'd2;
            2'b10:   size = 3'd4;
            default: size = 3'd1;
        endcase
        // The 33-bit sum keeps an access near 0xFFFFFFFF from wrapping into range.
        end_addr     = {1'b0, ReqAddr} + 33'(size) - 33'd1;
        out_of_range = end_addr >= 33'(MEM_BYTES);
        illegal      = (ReqFunct3[1:0] == 2'b11) || (ReqFunct3 == 3'b110) || (ReqFunct3[2] && ReqWr);
        misaligned   = ((ReqFunct3[1:0] == 2'b01) && ReqAddr[0]) ||
                       ((ReqFunct3[1:0] == 2'b10) && (ReqAddr[1:0] != 2'b00));
        req_err      = illegal || out_of_range || (misaligned && !ALLOW_MISALIGNED);
        req_split    = misaligned && ALLOW_MISALIGNED && !req_err;
    end

    // Byte assembly for split loads, including the byte arriving this cycle.
    always_comb begin
        last_k  = f3_q[1] ? 2'd3 : 2'd1;
        asm_nxt = asm_q;
        asm_nxt[{cnt_q, 3'b000} +: 8] = DataRd[7:0];
        if (f3_q[1])
            split_rdata = asm_nxt;
        else if (f3_q[2])
            split_rdata = {16'b0, asm_nxt[15:0]};
        else
            split_rdata = {{16{asm_nxt[15]}}, asm_nxt[15:0]};
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, regardless of process ordering.
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and memory/handshake outputs.
    always_comb begin
        // NOTE: every output gets a default first; a path that leaves one
        // unassigned would infer a latch.
        state_nxt = state;
        ReqReady  = 1'b0;
        RspValid  = 1'b0;
        Address   = 32'b0;
        DataWr    = 32'b0;
        DMWr      = 1'b0;
        DMCtrl    = 3'b000;
        case (state)
            IDLE: begin
                ReqReady = 1'b1;
                // Errors also pass through ACCESS (with the port idle) so every
                // non-split response arrives two cycles after acceptance.
                if (ReqValid)
                    state_nxt = req_split ? SPLIT : ACCESS;
            end
            ACCESS: begin
                if (!err_q) begin
                    Address = addr_q;
                    DMCtrl  = f3_q;
                    DataWr  = wdata_q;
                    DMWr    = wr_q;
                end
                state_nxt = RESP;
            end
            SPLIT: begin
                Address = addr_q + 32'(cnt_q);
                DMCtrl  = wr_q ? 3'b000 : 3'b100;
                DataWr  = {24'b0, wdata_q[{cnt_q, 3'b000} +: 8]};
                DMWr    = wr_q;
                if (cnt_q == last_k)
                    state_nxt = RESP;
            end
            RESP: begin
                RspValid = 1'b1;
                if (RspReady)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, split counter, load assembly and response registers.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset too so the response outputs read 0
        // right after reset rather than stale data.
        if (!rst_n) begin
            wr_q      <= 1'b0;
            addr_q    <= 32'b0;
            wdata_q   <= 32'b0;
            f3_q      <= 3'b000;
            err_q     <= 1'b0;
            cnt_q     <= 2'd0;
            asm_q     <= 32'b0;
            rdata_q   <= 32'b0;
            rsp_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        wr_q      <= ReqWr;
                        addr_q    <= ReqAddr;
                        wdata_q   <= ReqWData;
                        f3_q      <= ReqFunct3;
                        err_q     <= req_err;
                        cnt_q     <= 2'd0;
                        asm_q     <= 32'b0;
                        rdata_q   <= 32'b0;
                        rsp_err_q <= 1'b0;
                    end
                end
                ACCESS: begin
                    rsp_err_q <= err_q;
                    rdata_q   <= (!err_q && !wr_q) ? DataRd : 32'b0;
                end
                SPLIT: begin
                    asm_q <= asm_nxt;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == last_k)
                        rdata_q <= wr_q ? 32'b0 : split_rdata;
                end
                default: ;
            endcase
        end
    end

    assign RspRData = rdata_q;
    assign RspErr   = rsp_err_q;

endmodule
